// File: rtl/bus_timer_io.sv
// bus_timer_io: memory-mapped GPIO port plus 16-bit down-counting interval
// timer with interrupt, answering CPU bus cycles with one-cycle read latency.
module bus_timer_io #(
  parameter int          ADDR_WIDTH = 4,
  parameter logic [15:0] T1_RST     = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  input  logic                  wrt_en,
  input  logic                  chip_select,
  input  logic [7:0]            port_in,
  output logic [7:0]            port_out,
  output logic [7:0]            port_oe,
  output logic                  irq_n
);

  localparam logic [3:0] A_PORT_OUT = 4'h0;
  localparam logic [3:0] A_DDR      = 4'h1;
  localparam logic [3:0] A_PORT_IN  = 4'h2;
  localparam logic [3:0] A_LATCH_LO = 4'h3;
  localparam logic [3:0] A_LATCH_HI = 4'h4;
  localparam logic [3:0] A_CNT_LO   = 4'h5;
  localparam logic [3:0] A_CNT_HI   = 4'h6;
  localparam logic [3:0] A_CTRL     = 4'h7;
  localparam logic [3:0] A_STATUS   = 4'h8;

  typedef enum logic {IDLE, RUN} state_t;

  logic [3:0]  addr_lo;
  logic        wr_en, rd_en;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] latch_q, latch_d;
  logic        flag_q, flag_d;
  logic        cont_q, cont_d;
  logic        ien_q, ien_d;
  logic [7:0]  port_out_q, port_out_d;
  logic [7:0]  ddr_q, ddr_d;
  logic [7:0]  sync1_q, sync1_d;
  logic [7:0]  sync2_q, sync2_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        irq_n_q, irq_n_d;
  logic [7:0]  rdata;

  // Only the low four address bits select a register; wider buses alias.
  assign addr_lo = address[3:0];
  assign wr_en   = chip_select & wrt_en;
  assign rd_en   = chip_select & ~wrt_en;

  // Bus-written configuration registers, port_in synchroniser and irq.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    port_out_d = port_out_q;
    ddr_d      = ddr_q;
    latch_d    = latch_q;
    cont_d     = cont_q;
    ien_d      = ien_q;
    sync1_d    = port_in;
    sync2_d    = sync1_q;
    if (wr_en) begin
      unique case (addr_lo)
        A_PORT_OUT: port_out_d = data_in;
        A_DDR:      ddr_d      = data_in;
        A_LATCH_LO: latch_d    = {latch_q[15:8], data_in};
        A_LATCH_HI: latch_d    = {data_in, latch_q[7:0]};
        A_CTRL: begin
          cont_d = data_in[0];
          ien_d  = data_in[1];
        end
        default: ;
      endcase
    end
    // irq follows the next FLAG/IEN so it appears on the same edge as FLAG.
    irq_n_d = ~(flag_d & ien_d);
  end

  // Timer FSM: later assignments carry higher priority (clear < underflow < stop < start).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    if (wr_en && addr_lo == A_STATUS && data_in[0]) flag_d = 1'b0;
    if (state_q == RUN) begin
      if (cnt_q != 16'h0000) begin
        cnt_d = cnt_q - 16'd1;
      end else begin
        flag_d = 1'b1;
        if (cont_q) cnt_d   = latch_q;
        else        state_d = IDLE;
      end
    end
    if (wr_en && addr_lo == A_CTRL && data_in[2]) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
    end
    if (wr_en && addr_lo == A_LATCH_HI) begin
      state_d = RUN;
      cnt_d   = {data_in, latch_q[7:0]};
    end
  end

  // Read mux from current register state; data_out holds when not reading.
  always_comb begin
    rdata = 8'h00;
    unique case (addr_lo)
      A_PORT_OUT: rdata = port_out_q;
      A_DDR:      rdata = ddr_q;
      A_PORT_IN:  rdata = sync2_q;
      A_LATCH_LO: rdata = latch_q[7:0];
      A_LATCH_HI: rdata = latch_q[15:8];
      A_CNT_LO:   rdata = cnt_q[7:0];
      A_CNT_HI:   rdata = cnt_q[15:8];
      A_CTRL:     rdata = {6'b000000, ien_q, cont_q};
      A_STATUS:   rdata = {6'b000000, (state_q == RUN), flag_q};
      default:    rdata = 8'h00;
    endcase
    data_out_d = rd_en ? rdata : data_out_q;
  end

  // State register for every flop in the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 16'h0000;
      latch_q    <= T1_RST;
      flag_q     <= 1'b0;
      cont_q     <= 1'b0;
      ien_q      <= 1'b0;
      port_out_q <= 8'h00;
      ddr_q      <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      data_out_q <= 8'h00;
      irq_n_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      flag_q     <= flag_d;
      cont_q     <= cont_d;
      ien_q      <= ien_d;
      port_out_q <= port_out_d;
      ddr_q      <= ddr_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      data_out_q <= data_out_d;
      irq_n_q    <= irq_n_d;
    end
  end

  assign data_out = data_out_q;
  assign port_out = port_out_q;
  assign port_oe  = ddr_q;
  assign irq_n    = irq_n_q;

endmodule

// File: tb/tb_bus_timer_io.sv
// tb_bus_timer_io: scenario tasks drive bus cycles; read expectations go to a
// scoreboard queue and are compared when data_out updates after the read edge.
module tb_bus_timer_io;

  logic       clk;
  logic       reset_n;
  logic [3:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       wrt_en;
  logic       chip_select;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic [7:0] port_oe;
  logic       irq_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  bus_timer_io #(.ADDR_WIDTH(4), .T1_RST(16'hFFFF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out),
    .wrt_en      (wrt_en),
    .chip_select (chip_select),
    .port_in     (port_in),
    .port_out    (port_out),
    .port_oe     (port_oe),
    .irq_n       (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every read edge pops one expectation and compares data_out.
  always @(posedge clk) begin
    if (reset_n && chip_select && !wrt_en) begin
      #2;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: read seen with no expectation queued, data_out=%h", data_out);
      end else begin
        rd_exp_t e;
        e = sb_q.pop_front();
        if (data_out !== e.exp) begin
          errors++;
          $display("FAIL %s: data_out=%h expected %h", e.tag, data_out, e.exp);
        end
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic bus_cycle(input logic [3:0] a, input logic [7:0] d,
                           input logic we, input logic cs);
    address     = a;
    data_in     = d;
    wrt_en      = we;
    chip_select = cs;
    @(posedge clk);
    #1;
    chip_select = 1'b0;
    wrt_en      = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bus_cycle(a, d, 1'b1, 1'b1);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    rd_exp_t e;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
    bus_cycle(a, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (irq_n !== 1'b1 || port_oe !== 8'h00 || port_out !== 8'h00 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: irq_n=%b port_oe=%h port_out=%h data_out=%h expected 1 00 00 00",
               irq_n, port_oe, port_out, data_out);
    end
    bus_read(4'h8, 8'h00, "reset_status");
    bus_read(4'h7, 8'h00, "reset_ctrl");
    bus_read(4'h3, 8'hFF, "reset_latch_lo");
    bus_read(4'h4, 8'hFF, "reset_latch_hi");
    // Start a free-running count with interrupts, then reset mid-run.
    bus_write(4'h1, 8'hFF);
    bus_write(4'h7, 8'h03);
    bus_write(4'h3, 8'h05);
    bus_write(4'h4, 8'h00);
    idle(8);
    checks++;
    if (irq_n !== 1'b0) begin
      errors++;
      $display("FAIL prereset_irq: irq_n=%b expected 0", irq_n);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq_n !== 1'b1 || port_oe !== 8'h00 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: irq_n=%b port_oe=%h data_out=%h expected 1 00 00",
               irq_n, port_oe, data_out);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus_read(4'h8, 8'h00, "postreset_status");
    bus_read(4'h5, 8'h00, "postreset_cnt_lo");
    bus_read(4'h7, 8'h00, "postreset_ctrl");
  endtask

  task automatic test_gpio();
    bus_write(4'h1, 8'hF0);
    bus_write(4'h0, 8'hA5);
    checks++;
    if (port_oe !== 8'hF0 || port_out !== 8'hA5) begin
      errors++;
      $display("FAIL gpio_pins: port_oe=%h port_out=%h expected F0 A5", port_oe, port_out);
    end
    port_in = 8'h3C;
    idle(2);
    bus_read(4'h2, 8'h3C, "gpio_port_in");
    bus_read(4'h1, 8'hF0, "gpio_ddr_rd");
    bus_read(4'h0, 8'hA5, "gpio_out_rd");
    // Two synchroniser stages: a new pin value needs two edges before it is read.
    port_in = 8'hC3;
    bus_read(4'h2, 8'h3C, "gpio_sync_0");
    bus_read(4'h2, 8'h3C, "gpio_sync_1");
    bus_read(4'h2, 8'hC3, "gpio_sync_2");
  endtask

  task automatic test_one_shot();
    bus_write(4'h7, 8'h02);
    bus_write(4'h3, 8'h04);
    bus_write(4'h4, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      logic exp_irq;
      idle(1);
      exp_irq = (i == 5) ? 1'b0 : 1'b1;
      checks++;
      if (irq_n !== exp_irq) begin
        errors++;
        $display("FAIL oneshot_irq_clk%0d: irq_n=%b expected %b", i, irq_n, exp_irq);
      end
    end
    bus_read(4'h8, 8'h01, "oneshot_status");
    bus_read(4'h5, 8'h00, "oneshot_cnt_lo");
    bus_read(4'h6, 8'h00, "oneshot_cnt_hi");
    bus_write(4'h8, 8'h01);
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_clear: irq_n=%b expected 1", irq_n);
    end
    bus_read(4'h8, 8'h00, "oneshot_status_cleared");
  endtask

  task automatic test_continuous();
    logic [15:0] m;
    bus_write(4'h7, 8'h03);
    bus_write(4'h3, 8'h02);
    bus_write(4'h4, 8'h00);
    // Reference counter model: reload 2 after reaching 0, period 3 clocks.
    m = 16'h0002;
    for (int k = 1; k <= 7; k++) begin
      bus_read(4'h5, m[7:0], $sformatf("cont_cnt_%0d", k));
      m = (m == 16'h0000) ? 16'h0002 : m - 16'h0001;
    end
    // Restart, clear FLAG, then clear again on the underflow edge.
    bus_write(4'h4, 8'h00);
    bus_write(4'h8, 8'h01);
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL cont_clear: irq_n=%b expected 1", irq_n);
    end
    idle(1);
    bus_write(4'h8, 8'h01);
    checks++;
    if (irq_n !== 1'b0) begin
      errors++;
      $display("FAIL cont_set_beats_clear: irq_n=%b expected 0", irq_n);
    end
    bus_read(4'h8, 8'h03, "cont_status");
  endtask

  task automatic test_restart_stop();
    bus_write(4'h7, 8'h06);
    bus_write(4'h8, 8'h01);
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL stop_clear: irq_n=%b expected 1", irq_n);
    end
    bus_write(4'h3, 8'h00);
    bus_write(4'h4, 8'h01);
    bus_write(4'h4, 8'h02);
    bus_read(4'h6, 8'h02, "restart_cnt_hi");
    bus_read(4'h5, 8'hFF, "restart_cnt_lo");
    bus_write(4'h7, 8'h06);
    idle(10);
    bus_read(4'h5, 8'hFE, "stop_cnt_lo");
    bus_read(4'h6, 8'h01, "stop_cnt_hi");
    bus_read(4'h8, 8'h00, "stop_status");
    bus_read(4'h7, 8'h02, "stop_ctrl_rd");
  endtask

  task automatic test_decode();
    bus_cycle(4'h0, 8'h00, 1'b1, 1'b0);
    bus_cycle(4'h1, 8'h00, 1'b1, 1'b0);
    checks++;
    if (port_out !== 8'hA5 || port_oe !== 8'hF0) begin
      errors++;
      $display("FAIL decode_cs0: port_out=%h port_oe=%h expected A5 F0", port_out, port_oe);
    end
    bus_write(4'hC, 8'h5A);
    bus_read(4'hC, 8'h00, "decode_unmapped_rd");
    bus_read(4'h8, 8'h00, "decode_no_start");
    bus_read(4'h0, 8'hA5, "decode_port_out");
    bus_cycle(4'hC, 8'h00, 1'b0, 1'b0);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL decode_cs0_read_hold: data_out=%h expected A5", data_out);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    address     = 4'h0;
    data_in     = 8'h00;
    wrt_en      = 1'b0;
    chip_select = 1'b0;
    port_in     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    test_reset();
    test_gpio();
    test_one_shot();
    test_continuous();
    test_restart_stop();
    test_decode();
    idle(2);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expectations unconsumed, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
